shift_register_univ: RTL and testbench

- Parametrised universal shift register; successor to the single-bit D flip-flop with reset.
- Per cycle it holds, shifts right, shifts left or parallel-loads a WIDTH-bit word, with a synchronous clear and a clock enable.
- A shift counter and a one-cycle done pulse report when a full word has been shifted since the last load.
- Used as a serialiser/deserialiser and general staging register across the design.

---
 rtl/shift_register_univ.sv | 91 +++++++++
 tb/tb_shift_register_univ.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with synchronous clear, clock enable, saturating shift counter and a
// one-cycle done pulse when a full word has been shifted since the last load.
// Optional macro SHIFT_REGISTER_ROTATE_EN adds input rot: shifts recirculate
// the outgoing bit instead of taking sin_r / sin_l.
module shift_register_univ #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       ck,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_r,
  input  logic                       sin_l,
`ifdef SHIFT_REGISTER_ROTATE_EN
  input  logic                       rot,
`endif
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic fill_r;
  logic fill_l;

  // Select the bit entering each end on a shift (serial input or recirculated bit)
  always_comb begin
    fill_r = sin_r;
    fill_l = sin_l;
`ifdef SHIFT_REGISTER_ROTATE_EN
    if (rot) begin
      fill_r = q[0];
      fill_l = q[WIDTH-1];
    end
`endif
  end

  // Register, counter and done pulse; clear beats enable, enable beats mode
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      q    <= INIT;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        q   <= INIT;
        cnt <= '0;
      end else if (en) begin
        unique case (mode)
          MODE_HOLD: ;
          MODE_RIGHT: begin
            q    <= {fill_r, q[WIDTH-1:1]};
            // done fires only on the WIDTH-1 -> WIDTH transition, so a
            // saturated counter never re-pulses
            done <= (cnt == CNT_LAST);
            if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
          end
          MODE_LEFT: begin
            q    <= {q[WIDTH-2:0], fill_l};
            done <= (cnt == CNT_LAST);
            if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
          end
          MODE_LOAD: begin
            q   <= d;
            cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_univ.sv
// Testbench for shift_register_univ (WIDTH=8, INIT=8'hA5): a directed vector
// table, hand-written reset / rotate sequences, then random stimulus against
// an arithmetic reference model. Builds with or without SHIFT_REGISTER_ROTATE_EN.
module tb_shift_register_univ;

  localparam int         W     = 8;
  localparam logic [7:0] INITV = 8'hA5;

  logic       ck;
  logic       reset;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_r;
  logic       sin_l;
  logic       rot;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] cnt;
  logic       done;

  int vectors;
  int miscompares;

  shift_register_univ #(.WIDTH(W), .INIT(INITV)) dut (
    .ck(ck),
    .reset(reset),
    .en(en),
    .clr(clr),
    .mode(mode),
    .d(d),
    .sin_r(sin_r),
    .sin_l(sin_l),
`ifdef SHIFT_REGISTER_ROTATE_EN
    .rot(rot),
`endif
    .q(q),
    .sout_r(sout_r),
    .sout_l(sout_l),
    .cnt(cnt),
    .done(done)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] eq;
    int         ec;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [7:0] mq;
  int         mcnt;
  logic       mdone;

  function automatic vec_t mk(logic c, logic e, logic [1:0] m, logic [7:0] dd,
                              logic sr, logic sl, logic [7:0] eq, int ec, logic ed);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.d = dd; v.sin_r = sr; v.sin_l = sl;
    v.eq = eq; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq, input int ec, input logic ed);
    cmp({tag, ".q"},      64'(q),      64'(eq));
    cmp({tag, ".cnt"},    64'(cnt),    64'(ec));
    cmp({tag, ".done"},   64'(done),   64'(ed));
    cmp({tag, ".sout_r"}, 64'(sout_r), 64'(eq[0]));
    cmp({tag, ".sout_l"}, 64'(sout_l), 64'(eq[7]));
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic rot_on();
`ifdef SHIFT_REGISTER_ROTATE_EN
    return rot;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: one clock edge using the currently driven inputs
  task automatic model_step();
    int in_bit;
    if (clr) begin
      mq = INITV; mcnt = 0; mdone = 1'b0;
    end else if (!en || mode == 2'b00) begin
      mdone = 1'b0;
    end else if (mode == 2'b11) begin
      mq = d; mcnt = 0; mdone = 1'b0;
    end else begin
      if (mode == 2'b01) begin
        in_bit = rot_on() ? int'(mq % 2) : int'(sin_r);
        mq = 8'((int'(mq) / 2) + in_bit * 128);
      end else begin
        in_bit = rot_on() ? int'(mq / 128) : int'(sin_l);
        mq = 8'(((int'(mq) * 2) % 256) + in_bit);
      end
      mdone = (mcnt + 1 == W);
      mcnt  = (mcnt + 1 > W) ? W : mcnt + 1;
    end
  endtask

  task automatic drive_idle();
    clr = 0; en = 1; mode = 2'b00; d = 8'h00; sin_r = 0; sin_l = 0; rot = 0;
  endtask

  initial begin
    logic [7:0] rq;
    vectors = 0;
    miscompares = 0;
    drive_idle();

    // Asynchronous reset from a non-INIT value, asserted between edges
    reset = 1'b1;
    tick();
    mode = 2'b11; d = 8'h3C;
    tick();
    cmp("pre_reset_load.q", 64'(q), 64'(8'h3C));
    #3 reset = 1'b0;
    #1;
    check_all("async_reset", INITV, 0, 1'b0);
    mode = 2'b00;
    tick();
    check_all("reset_held", INITV, 0, 1'b0);
    #3 reset = 1'b1;
    tick();
    check_all("post_release_hold", INITV, 0, 1'b0);

    // Directed table (expected values worked out by hand)
    vecs.push_back(mk(0,1,2'b11,8'h81,0,0, 8'h81,0,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h40,1,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h20,2,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h10,3,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h08,4,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h04,5,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h02,6,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h01,7,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h00,8,1));
    vecs.push_back(mk(0,1,2'b00,8'h00,0,0, 8'h00,8,0));
    // clear beats en=0 and load
    vecs.push_back(mk(1,0,2'b11,8'hFF,0,0, 8'hA5,0,0));
    // left-shift deserialise 1,0,1,1,0,0,1,0
    vecs.push_back(mk(0,1,2'b10,8'h00,0,1, 8'h4B,1,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h96,2,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,1, 8'h2D,3,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,1, 8'h5B,4,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'hB6,5,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h6C,6,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,1, 8'hD9,7,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'hB2,8,1));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h64,8,0));
    // en=0 holds q and cnt for three cycles
    vecs.push_back(mk(0,0,2'b01,8'h00,1,1, 8'h64,8,0));
    vecs.push_back(mk(0,0,2'b01,8'h00,1,1, 8'h64,8,0));
    vecs.push_back(mk(0,0,2'b01,8'h00,1,1, 8'h64,8,0));
    // re-arm: load, shift 5, reload, shift 8 (mixed directions)
    vecs.push_back(mk(0,1,2'b11,8'h00,0,0, 8'h00,0,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,1,0, 8'h80,1,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,1,0, 8'hC0,2,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,1,0, 8'hE0,3,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,1,0, 8'hF0,4,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,1,0, 8'hF8,5,0));
    vecs.push_back(mk(0,1,2'b11,8'h0F,0,0, 8'h0F,0,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h1E,1,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h3C,2,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h78,3,0));
    vecs.push_back(mk(0,1,2'b01,8'h00,1,0, 8'hBC,4,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'h78,5,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'hF0,6,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'hE0,7,0));
    vecs.push_back(mk(0,1,2'b10,8'h00,0,0, 8'hC0,8,1));
    vecs.push_back(mk(0,1,2'b01,8'h00,0,0, 8'h60,8,0));

    foreach (vecs[i]) begin
      clr = vecs[i].clr; en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
      sin_r = vecs[i].sin_r; sin_l = vecs[i].sin_l; rot = 1'b0;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ec, vecs[i].ed);
    end

    // Reset mid-shift discards the count; a full word is needed for done
    drive_idle();
    mode = 2'b01;
    repeat (3) tick();
    #3 reset = 1'b0;
    #1;
    check_all("midshift_reset", INITV, 0, 1'b0);
    #3 reset = 1'b1;
    rq = INITV;
    for (int k = 1; k <= W; k++) begin
      sin_r = k[0];
      tick();
      rq = {sin_r, rq[7:1]};
      check_all($sformatf("rearm_shift%0d", k), rq, k, (k == W));
    end

    // Rotate sequence: recirculates with the feature, drains to zero without it
    drive_idle();
    mode = 2'b11; d = 8'h01;
    tick();
    mode = 2'b01; rot = 1'b1; sin_r = 1'b0;
    rq = 8'h01;
    for (int k = 1; k <= W; k++) begin
      tick();
      rq = {(rot_on() ? rq[0] : 1'b0), rq[7:1]};
      check_all($sformatf("rot_shift%0d", k), rq, k, (k == W));
    end
`ifdef SHIFT_REGISTER_ROTATE_EN
    cmp("rot_full_circle.q", 64'(q), 64'(8'h01));
`else
    cmp("norot_drained.q", 64'(q), 64'(8'h00));
`endif

    // Random stimulus against the reference model
    drive_idle();
    #3 reset = 1'b0;
    #1;
    mq = INITV; mcnt = 0; mdone = 1'b0;
    check_all("rand_reset", mq, mcnt, mdone);
    #3 reset = 1'b1;
    for (int n = 0; n < 600; n++) begin
      clr   = ($urandom_range(0, 29) == 0);
      en    = ($urandom_range(0, 7) != 0);
      mode  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      d     = 8'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      rot   = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1;
        mq = INITV; mcnt = 0; mdone = 1'b0;
        check_all($sformatf("rand%0d_areset", n), mq, mcnt, mdone);
        #2 reset = 1'b1;
      end
      model_step();
      tick();
      check_all($sformatf("rand%0d", n), mq, mcnt, mdone);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
